// File: rtl/four_req_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant, bounded
// hold time under contention and a one-cycle gap between successive owners.
module four_req_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       preempt,
    output logic       any_req,
    output logic [1:0] pair_req
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] owner_nxt;
    logic       preempt_nxt;
    logic [1:0] winner;
    logic [3:0] winner_oh;
    logic       others_req;

    // Two-level OR tree: the pair terms double as the request-detect summary.
    assign pair_req = {req[3] | req[2], req[1] | req[0]};
    assign any_req  = pair_req[1] | pair_req[0];

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        winner = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req[ptr + 2'(3 - i)]) begin
                winner = ptr + 2'(3 - i);
            end
        end
    end

    assign winner_oh  = 4'b0001 << winner;
    assign others_req = |(req & ~(4'b0001 << owner));

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        grant_nxt    = grant;
        owner_nxt    = owner;
        preempt_nxt  = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (any_req) begin
                    state_nxt    = GRANT;
                    grant_nxt    = winner_oh;
                    owner_nxt    = winner;
                    hold_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_nxt = GAP;
                    grant_nxt = '0;
                    ptr_nxt   = owner + 2'd1;
                end else if (hold_cnt == HOLD_LAST && others_req) begin
                    state_nxt   = GAP;
                    grant_nxt   = '0;
                    preempt_nxt = 1'b1;
                    ptr_nxt     = owner + 2'd1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            grant    <= grant_nxt;
            owner    <= owner_nxt;
            busy     <= |grant_nxt;
            preempt  <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_four_req_arbiter.sv
// Bench for four_req_arbiter: directed scenarios plus random requests, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_four_req_arbiter;

    localparam int unsigned MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy, preempt, any_req;
    logic [1:0] pair_req;

    int errors = 0;
    int checks = 0;

    // Model: who holds the resource and for how many cycles so far.
    bit m_active = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_held   = 0;
    bit m_pre    = 0;

    four_req_arbiter #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .preempt  (preempt),
        .any_req  (any_req),
        .pair_req (pair_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_grant();
        return m_active ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    // Apply one clock edge of the arbitration rules to the model.
    task automatic model_edge(input logic [3:0] r, input logic rn);
        int others;
        if (!rn) begin
            m_active = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_pre = 0;
            return;
        end
        m_pre = 0;
        if (m_active) begin
            others = int'(r) & ~(1 << m_owner);
            if (!r[m_owner]) begin
                m_active = 0;
                m_ptr = (m_owner + 1) % 4;
            end else if (m_held >= int'(MH) && others != 0) begin
                m_active = 0;
                m_pre = 1;
                m_ptr = (m_owner + 1) % 4;
            end else begin
                m_held++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 3; k >= 0; k--) begin
                if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            m_active = 1;
            m_held = 1;
        end
    endtask

    task automatic compare_all();
        int exp_cnt;
        check("grant", {4'b0, grant}, {4'b0, m_grant()});
        check("owner", {6'b0, owner}, 8'(m_owner));
        check("busy", {7'b0, busy}, {7'b0, m_active});
        check("preempt", {7'b0, preempt}, {7'b0, m_pre});
        check("any_req", {7'b0, any_req}, {7'b0, req != 4'b0000});
        check("pair_req", {6'b0, pair_req}, {6'b0, req[3:2] != 2'b00, req[1:0] != 2'b00});
        if (m_active) begin
            exp_cnt = (m_held - 1 > int'(MH) - 1) ? int'(MH) - 1 : m_held - 1;
            check("hold_cnt", dut.hold_cnt, 8'(exp_cnt));
        end
    endtask

    task automatic tick();
        model_edge(req, rst_n);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req = r;
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] seq[$];

    initial begin
        // Reset with all requests high.
        rst_n = 1'b0;
        req = 4'b1111;
        tick();
        tick();
        check("rst_grant", {4'b0, grant}, 8'h00);
        check("rst_any_req", {7'b0, any_req}, 8'h01);
        check("rst_pair_req", {6'b0, pair_req}, 8'h03);
        rst_n = 1'b1;
        tick();
        check("rst_first_grant", {4'b0, grant}, 8'h01);

        // Single requester, release, then pointer-directed pick.
        do_reset(4'b0100);
        tick();
        check("single_grant", {4'b0, grant}, 8'h04);
        check("single_owner", {6'b0, owner}, 8'h02);
        req = 4'b0000;
        tick();
        check("single_release", {4'b0, grant}, 8'h00);
        tick();
        req = 4'b1001;
        tick();
        check("ptr3_pick", {4'b0, grant}, 8'h08);

        // Full contention: MH cycles per owner, forced gaps between.
        seq.delete();
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < int'(MH); c++) seq.push_back(4'(1 << o));
            seq.push_back(4'b0000);
        end
        seq.push_back(4'b0001);
        do_reset(4'b1111);
        foreach (seq[i]) begin
            tick();
            check("contend_grant", {4'b0, grant}, {4'b0, seq[i]});
            check("contend_preempt", {7'b0, preempt}, {7'b0, seq[i] == 4'b0000});
        end

        // Saturation with a lone requester, then a late competitor.
        do_reset(4'b0010);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("sat_grant", {4'b0, grant}, 8'h02);
            check("sat_preempt", {7'b0, preempt}, 8'h00);
            if (i >= int'(MH) - 1) check("sat_cnt", dut.hold_cnt, 8'(MH - 1));
        end
        req = 4'b1010;
        tick();
        check("late_drop", {4'b0, grant}, 8'h00);
        check("late_preempt", {7'b0, preempt}, 8'h01);
        tick();
        check("late_grant", {4'b0, grant}, 8'h08);

        // Voluntary release coinciding with hold limit.
        do_reset(4'b0011);
        for (int i = 0; i < int'(MH); i++) tick();
        check("simul_cnt", dut.hold_cnt, 8'(MH - 1));
        req = 4'b0010;
        tick();
        check("simul_gap", {4'b0, grant}, 8'h00);
        check("simul_preempt", {7'b0, preempt}, 8'h00);
        tick();
        check("simul_next", {4'b0, grant}, 8'h02);

        // Reset while requester 2 owns the grant.
        do_reset(4'b1111);
        for (int i = 0; i < 20 && m_grant() != 4'b0100; i++) tick();
        check("mid_reach", {4'b0, grant}, 8'h04);
        rst_n = 1'b0;
        tick();
        check("mid_rst_grant", {4'b0, grant}, 8'h00);
        rst_n = 1'b1;
        tick();
        check("mid_after_grant", {4'b0, grant}, 8'h01);

        // Random requests with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
